rs_encoder: RTL



---
 rtl/rs_gf8_pkg.sv | 52 +++++
 rtl/gf8_const_multiplier.sv | 18 +
 rtl/rs_encoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rs_gf8_pkg.sv
// rs_gf8_pkg
//   GF(8) arithmetic shared by the RS(7,3) encoder and decoder.
//   Symbol bit order: bit[2] holds the x^0 coefficient, bit[0] holds x^2.
//   Field built on the primitive polynomial x^3+x+1.
//   Contents: code sizes, symbol type, a^k antilog table and its log inverse,
//   generator taps G3..G0, gf_mul(), and the encoder FSM state type.
package rs_gf8_pkg;

    localparam int SYM_W = 3;
    localparam int N     = 7;
    localparam int K     = 3;
    localparam int NPAR  = N - K;

    // Number of nonzero field elements (multiplicative group order)
    localparam int GF_ORD = 7;

    typedef logic [SYM_W-1:0] sym_t;

    // ALPHA[k] = a^k
    localparam sym_t ALPHA [0:6] = '{
        3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111, 3'b101
    };

    // LOG[s] = k such that a^k = s; LOG[0] is a don't-care
    localparam int LOG [0:7] = '{0, 2, 1, 4, 0, 6, 3, 5};

    // g(x) = x^4 + a^3 x^3 + a^0 x^2 + a^1 x + a^3
    localparam sym_t G3 = 3'b110;
    localparam sym_t G2 = 3'b100;
    localparam sym_t G1 = 3'b010;
    localparam sym_t G0 = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } enc_state_t;

    // Multiply via log/antilog; zero operands short-circuit to zero
    function automatic sym_t gf_mul(sym_t a, sym_t b);
        int         e;
        logic [2:0] idx;
        if (a == '0 || b == '0) begin
            return '0;
        end else begin
            e   = (LOG[a] + LOG[b]) % GF_ORD;
            idx = 3'(e);
            return ALPHA[idx];
        end
    endfunction

endpackage

// File: rtl/gf8_const_multiplier.sv
// gf8_const_multiplier
//   Combinational GF(8) multiply of a symbol by a fixed coefficient COEF.
//   Ports:
//     sym      in   3  input symbol
//     product  out  3  sym * COEF
module gf8_const_multiplier
    import rs_gf8_pkg::*;
#(
    parameter sym_t COEF = 3'b100
) (
    input  sym_t sym,
    output sym_t product
);

    // Constant operand lets synthesis fold the tables into a few XORs
    assign product = gf_mul(sym, COEF);

endmodule

// File: rtl/rs_encoder.sv
// rs_encoder
//   Systematic RS(7,3) encoder over GF(8). Message symbols are shifted
//   m2, m1, m0 through an LFSR dividing by g(x); the 4 remainder symbols
//   become the parity appended below the message.
//   Ports:
//     clk        in   1   clock, rising edge
//     reset      in   1   synchronous, active-high
//     msg_valid  in   1   message present
//     msg_ready  out  1   encoder idle, can accept a message
//     message    in   9   {m2,m1,m0}
//     cw_valid   out  1   codeword holds a finished codeword
//     cw_ready   in   1   sink accepts codeword
//     codeword   out  21  {m2,m1,m0,p3,p2,p1,p0}
//     busy       out  1   high outside IDLE
module rs_encoder #(
    parameter int SYM_W = rs_gf8_pkg::SYM_W,
    parameter int N     = rs_gf8_pkg::N,
    parameter int K     = rs_gf8_pkg::K
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [K*SYM_W-1:0] message,
    output logic               cw_valid,
    input  logic               cw_ready,
    output logic [N*SYM_W-1:0] codeword,
    output logic               busy
);

    import rs_gf8_pkg::*;

    localparam int P = N - K;

    if (SYM_W != 3 || N != 7 || K != 3) begin : g_bad_param
        $error("rs_encoder supports only SYM_W=3, N=7, K=3");
    end

    localparam logic [1:0] LAST = 2'(K - 1);

    enc_state_t state, state_nxt;

    logic [K*SYM_W-1:0]          msg_q;
    logic [P-1:0][SYM_W-1:0]     par_q;
    logic [P-1:0][SYM_W-1:0]     par_nxt;
    logic [1:0]                  cnt;
    logic [N*SYM_W-1:0]          cw_q;
    sym_t                        sym_cur;
    sym_t                        fb;
    sym_t                        t3, t2, t1, t0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (msg_valid)     state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST)   state_nxt = DONE;
            DONE:    if (cw_ready)      state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        msg_ready = (state == IDLE);
        cw_valid  = (state == DONE);
        busy      = (state != IDLE);
        codeword  = cw_q;
    end

    // Highest-order message symbol enters the divider first
    always_comb begin
        case (cnt)
            2'd0:    sym_cur = msg_q[8:6];
            2'd1:    sym_cur = msg_q[5:3];
            default: sym_cur = msg_q[2:0];
        endcase
    end

    assign fb = sym_cur ^ par_q[3];

    gf8_const_multiplier #(.COEF(G3)) u_mul3 (.sym(fb), .product(t3));
    gf8_const_multiplier #(.COEF(G2)) u_mul2 (.sym(fb), .product(t2));
    gf8_const_multiplier #(.COEF(G1)) u_mul1 (.sym(fb), .product(t1));
    gf8_const_multiplier #(.COEF(G0)) u_mul0 (.sym(fb), .product(t0));

    assign par_nxt = {par_q[2] ^ t3, par_q[1] ^ t2, par_q[0] ^ t1, t0};

    // Datapath: message latch, LFSR, output register
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_q <= '0;
            par_q <= '0;
            cnt   <= '0;
            cw_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (msg_valid) begin
                        msg_q <= message;
                        par_q <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    par_q <= par_nxt;
                    if (cnt == LAST) begin
                        cnt  <= '0;
                        // Last shift: the remainder is final, capture it directly
                        cw_q <= {msg_q, par_nxt};
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
